// File: rtl/bus_mtimer_slave.sv
`default_nettype none
// ============================================================================
// Module : bus_mtimer_slave  (with bus_mtimer_pkg transfer types)
// RISC-V machine timer (mtime/mtimecmp/ctrl) answering dbus loads and stores.
// Rev    : 1.0
// ============================================================================

package bus_mtimer_pkg;
    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } ttype_e;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } tsize_e;
endpackage

module bus_mtimer_slave
    import bus_mtimer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0200_0000,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned PRESCALE    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bstart,
    input  logic        breq,
    input  ttype_e      ttype,
    input  tsize_e      tsize,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        bdone,
    output logic        berr,
    output logic        irq_timer
);

    localparam bit           NO_WAIT   = (WAIT_STATES == 0);
    localparam logic [3:0]   WAIT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);
    localparam int           PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    wait_q, wait_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    ttype_e        ttype_q, ttype_d;
    tsize_e        tsize_q, tsize_d;

    logic [31:0]   rdata_q, rdata_d;
    logic          bdone_q, bdone_d;
    logic          berr_q, berr_d;
    logic          irq_q, irq_d;

    logic [63:0]   mtime_q, mtime_d;
    logic [63:0]   mtimecmp_q, mtimecmp_d;
    logic          en_q, en_d;
    logic [PW-1:0] presc_q, presc_d;

    logic          w_accept;
    logic          w_commit;
    logic [31:0]   w_addr;
    logic [31:0]   w_wdata;
    ttype_e        w_ttype;
    tsize_e        w_tsize;
    logic          w_err;
    logic [2:0]    w_idx;
    logic [4:0]    w_shift;
    logic [31:0]   w_sel;
    logic [31:0]   w_rmask;
    logic [3:0]    w_be;
    logic [31:0]   w_bmask;
    logic [31:0]   w_wshift;
    logic          w_wr;
    logic          w_tick;

    function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [31:0] mask);
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    assign w_accept = bstart & breq;

    // ------------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ttype_d = ttype_q;
        tsize_d = tsize_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    ttype_d = ttype;
                    tsize_d = tsize;
                    wait_d  = WAIT_LOAD;
                    state_d = NO_WAIT ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_q == 4'd0) begin
                    state_d = S_DONE;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Without wait states the request commits on its own acceptance edge,
    // so the live bus fields stand in for the not-yet-captured copy.
    always_comb begin
        w_addr   = (state_q == S_IDLE) ? addr  : addr_q;
        w_wdata  = (state_q == S_IDLE) ? wdata : wdata_q;
        w_ttype  = (state_q == S_IDLE) ? ttype : ttype_q;
        w_tsize  = (state_q == S_IDLE) ? tsize : tsize_q;
        w_commit = ((state_q == S_IDLE) && w_accept && NO_WAIT) ||
                   ((state_q == S_WAIT) && (wait_q == 4'd0));
    end

    // ------------------------------------------------------------------------
    // Decode, read mux and write lane generation
    // ------------------------------------------------------------------------
    always_comb begin
        w_idx   = w_addr[4:2];
        w_shift = {w_addr[1:0], 3'b000};
        w_err   = (w_addr[31:5] != BASE_ADDR[31:5]) ||
                  ((w_tsize == HALF) && w_addr[0]) ||
                  ((w_tsize != BYTE) && (w_tsize != HALF) && (w_addr[1:0] != 2'b00));

        case (w_idx)
            3'd0:    w_sel = mtime_q[31:0];
            3'd1:    w_sel = mtime_q[63:32];
            3'd2:    w_sel = mtimecmp_q[31:0];
            3'd3:    w_sel = mtimecmp_q[63:32];
            3'd4:    w_sel = {31'd0, en_q};
            default: w_sel = 32'd0;
        endcase

        case (w_tsize)
            BYTE: begin
                w_rmask = 32'h0000_00FF;
                w_be    = 4'b0001 << w_addr[1:0];
            end
            HALF: begin
                w_rmask = 32'h0000_FFFF;
                w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_rmask = 32'hFFFF_FFFF;
                w_be    = 4'b1111;
            end
        endcase

        w_bmask  = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
        w_wshift = w_wdata << w_shift;
        w_wr     = w_commit && (w_ttype == WRITE) && !w_err;
    end

    always_comb begin
        bdone_d = w_commit;
        berr_d  = w_commit && w_err;
        rdata_d = 32'd0;
        if (w_commit && (w_ttype == READ) && !w_err) begin
            rdata_d = (w_sel >> w_shift) & w_rmask;
        end
    end

    // ------------------------------------------------------------------------
    // Timer registers
    // ------------------------------------------------------------------------
    always_comb begin
        w_tick  = en_q && (presc_q == PRESC_MAX);
        presc_d = (!en_q || w_tick) ? '0 : presc_q + PW'(1);

        // A write to either mtime half swallows a coincident increment.
        mtime_d = w_tick ? mtime_q + 64'd1 : mtime_q;
        if (w_wr && (w_idx == 3'd0 || w_idx == 3'd1)) begin
            mtime_d = mtime_q;
            if (w_idx == 3'd0) begin
                mtime_d[31:0] = merge_word(mtime_q[31:0], w_wshift, w_bmask);
            end else begin
                mtime_d[63:32] = merge_word(mtime_q[63:32], w_wshift, w_bmask);
            end
        end

        mtimecmp_d = mtimecmp_q;
        if (w_wr && (w_idx == 3'd2)) begin
            mtimecmp_d[31:0] = merge_word(mtimecmp_q[31:0], w_wshift, w_bmask);
        end
        if (w_wr && (w_idx == 3'd3)) begin
            mtimecmp_d[63:32] = merge_word(mtimecmp_q[63:32], w_wshift, w_bmask);
        end

        en_d = en_q;
        if (w_wr && (w_idx == 3'd4) && w_be[0]) begin
            en_d = w_wshift[0];
        end

        irq_d = (mtime_d >= mtimecmp_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wait_q     <= 4'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            ttype_q    <= READ;
            tsize_q    <= BYTE;
            rdata_q    <= 32'd0;
            bdone_q    <= 1'b0;
            berr_q     <= 1'b0;
            irq_q      <= 1'b0;
            mtime_q    <= 64'd0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            en_q       <= 1'b0;
            presc_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ttype_q    <= ttype_d;
            tsize_q    <= tsize_d;
            rdata_q    <= rdata_d;
            bdone_q    <= bdone_d;
            berr_q     <= berr_d;
            irq_q      <= irq_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            en_q       <= en_d;
            presc_q    <= presc_d;
        end
    end

    assign rdata     = rdata_q;
    assign bdone     = bdone_q;
    assign berr      = berr_q;
    assign irq_timer = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_mtimer_slave.sv
`default_nettype none
// ============================================================================
// Module : tb_bus_mtimer_slave
// Self-checking bench: instance 0 (no wait, PRESCALE 1), instance 1 (3 waits, PRESCALE 3).
// Rev    : 1.0
// ============================================================================
module tb_bus_mtimer_slave;
    import bus_mtimer_pkg::*;

    localparam logic [31:0] BASE = 32'h0200_0000;
    localparam int          WS[2] = '{0, 3};
    localparam int          PS1   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bstart_s[2];
    logic        breq_s[2];
    ttype_e      ttype_s[2];
    tsize_e      tsize_s[2];
    logic [31:0] addr_s[2];
    logic [31:0] wdata_s[2];
    logic [31:0] rdata_s[2];
    logic        bdone_s[2];
    logic        berr_s[2];
    logic        irq_s[2];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Register image of instance 0: mtime lo/hi, mtimecmp lo/hi
    logic [31:0] m0[4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bus_mtimer_slave #(.BASE_ADDR(BASE), .WAIT_STATES(0), .PRESCALE(1)) u0 (
        .clk(clk), .rst(rst), .bstart(bstart_s[0]), .breq(breq_s[0]),
        .ttype(ttype_s[0]), .tsize(tsize_s[0]), .addr(addr_s[0]), .wdata(wdata_s[0]),
        .rdata(rdata_s[0]), .bdone(bdone_s[0]), .berr(berr_s[0]), .irq_timer(irq_s[0])
    );

    bus_mtimer_slave #(.BASE_ADDR(BASE), .WAIT_STATES(3), .PRESCALE(PS1)) u1 (
        .clk(clk), .rst(rst), .bstart(bstart_s[1]), .breq(breq_s[1]),
        .ttype(ttype_s[1]), .tsize(tsize_s[1]), .addr(addr_s[1]), .wdata(wdata_s[1]),
        .rdata(rdata_s[1]), .bdone(bdone_s[1]), .berr(berr_s[1]), .irq_timer(irq_s[1])
    );

    // One bus transfer; reports latency (master sampling edges from acceptance),
    // the commit cycle, and bdone one cycle after the pulse.
    task automatic xfer(input int s, input logic wr, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic be, output int lat,
                        output int commit, output logic after);
        int acc;
        int n;
        @(posedge clk); #1;
        ttype_s[s]  = wr ? WRITE : READ;
        tsize_s[s]  = tsize_e'(sz);
        addr_s[s]   = a;
        wdata_s[s]  = wd;
        bstart_s[s] = 1'b1;
        breq_s[s]   = 1'b1;
        @(posedge clk); #1;
        acc         = cyc;
        bstart_s[s] = 1'b0;
        addr_s[s]   = $urandom;
        wdata_s[s]  = $urandom;
        tsize_s[s]  = tsize_e'(2'($urandom_range(0, 2)));
        n = 0;
        while (bdone_s[s] !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        rd     = rdata_s[s];
        be     = berr_s[s];
        lat    = cyc - acc + 1;
        commit = cyc;
        if (n >= 40) begin
            tests++; fails++;
            $display("FAIL xfer_timeout inst=%0d addr=%h got no bdone within 40 cycles", s, a);
            lat = -1;
        end
        @(posedge clk); #1;
        after = bdone_s[s];
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            tests++;
            if (bdone_s[s] !== 1'b0) begin fails++; $display("FAIL reset_bdone inst=%0d got=%b exp=0", s, bdone_s[s]); end
            tests++;
            if (berr_s[s] !== 1'b0) begin fails++; $display("FAIL reset_berr inst=%0d got=%b exp=0", s, berr_s[s]); end
            tests++;
            if (rdata_s[s] !== 32'd0) begin fails++; $display("FAIL reset_rdata inst=%0d got=%h exp=0", s, rdata_s[s]); end
            tests++;
            if (irq_s[s] !== 1'b0) begin fails++; $display("FAIL reset_irq inst=%0d got=%b exp=0", s, irq_s[s]); end
        end
        m0[0] = 32'd0;
        m0[1] = 32'd0;
        m0[2] = 32'hFFFF_FFFF;
        m0[3] = 32'hFFFF_FFFF;
    endtask

    task automatic test_word_read();
        logic [31:0] rd; logic be, af; int lat, cm;
        xfer(0, 1'b0, 2'b10, BASE + 32'h0C, 32'd0, rd, be, lat, cm, af);
        tests++;
        if (lat !== 1) begin fails++; $display("FAIL word_read_latency got=%0d exp=1", lat); end
        tests++;
        if (rd !== 32'hFFFF_FFFF) begin fails++; $display("FAIL word_read_rdata got=%h exp=ffffffff", rd); end
        tests++;
        if (be !== 1'b0) begin fails++; $display("FAIL word_read_berr got=%b exp=0", be); end
        tests++;
        if (af !== 1'b0) begin fails++; $display("FAIL word_read_bdone_once got=%b exp=0", af); end
    endtask

    task automatic test_byte_write();
        logic [31:0] rd; logic be, af; int lat, cm;
        xfer(0, 1'b1, 2'b00, BASE + 32'h09, 32'h0000_00AB, rd, be, lat, cm, af);
        m0[2] = 32'hFFFF_ABFF;
        tests++;
        if (be !== 1'b0) begin fails++; $display("FAIL byte_write_berr got=%b exp=0", be); end
        xfer(0, 1'b0, 2'b10, BASE + 32'h08, 32'd0, rd, be, lat, cm, af);
        tests++;
        if (rd !== 32'hFFFF_ABFF) begin fails++; $display("FAIL byte_write_word got=%h exp=ffffabff", rd); end
        xfer(0, 1'b0, 2'b01, BASE + 32'h0A, 32'd0, rd, be, lat, cm, af);
        tests++;
        if (rd !== 32'h0000_FFFF) begin fails++; $display("FAIL half_read got=%h exp=0000ffff", rd); end
        xfer(0, 1'b0, 2'b00, BASE + 32'h09, 32'd0, rd, be, lat, cm, af);
        tests++;
        if (rd !== 32'h0000_00AB) begin fails++; $display("FAIL byte_read got=%h exp=000000ab", rd); end
    endtask

    // Random accesses with counting disabled, checked against a word-array image.
    task automatic test_random();
        logic [31:0] rd, a, wd, word, exp; logic be, af, wr, outw, err, irq_exp; int lat, cm;
        int sz, off, nb, idx;
        for (int i = 0; i < 60; i++) begin
            sz   = $urandom_range(0, 2);
            wr   = 1'($urandom_range(0, 1));
            off  = $urandom_range(0, 31);
            if (wr && off >= 16 && off < 20) off = off ^ 8;
            outw = ($urandom_range(0, 7) == 0);
            a    = outw ? ((BASE ^ (32'h1 << $urandom_range(5, 31))) | 32'(off)) : (BASE | 32'(off));
            wd   = $urandom;
            nb   = 1 << sz;
            err  = outw || ((off % nb) != 0);
            idx  = off / 4;
            word = (idx < 4) ? m0[idx] : 32'd0;
            exp  = 32'd0;
            if (!wr && !err) begin
                exp = word >> (8 * (off % 4));
                if (nb < 4) exp = exp & ((32'h1 << (8 * nb)) - 1);
            end
            if (wr && !err && idx < 4) begin
                for (int b = 0; b < nb; b++) m0[idx][8 * ((off % 4) + b) +: 8] = wd[8 * b +: 8];
            end
            irq_exp = ({m0[1], m0[0]} >= {m0[3], m0[2]});
            xfer(0, wr, 2'(sz), a, wd, rd, be, lat, cm, af);
            tests++;
            if (lat !== 1) begin fails++; $display("FAIL rand_latency i=%0d got=%0d exp=1", i, lat); end
            tests++;
            if (be !== err) begin fails++; $display("FAIL rand_berr i=%0d addr=%h sz=%0d got=%b exp=%b", i, a, sz, be, err); end
            tests++;
            if (rd !== exp) begin fails++; $display("FAIL rand_rdata i=%0d addr=%h sz=%0d got=%h exp=%h", i, a, sz, rd, exp); end
            tests++;
            if (irq_s[0] !== irq_exp) begin fails++; $display("FAIL rand_irq i=%0d got=%b exp=%b", i, irq_s[0], irq_exp); end
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic be, af; int lat, cm;
        xfer(0, 1'b0, 2'b10, BASE + 32'h02, 32'd0, rd, be, lat, cm, af);
        tests++;
        if (be !== 1'b1 || rd !== 32'd0) begin fails++; $display("FAIL err_misaligned got berr=%b rdata=%h exp berr=1 rdata=0", be, rd); end
        xfer(0, 1'b1, 2'b10, BASE + 32'h40, 32'h1234_5678, rd, be, lat, cm, af);
        tests++;
        if (be !== 1'b1 || rd !== 32'd0) begin fails++; $display("FAIL err_window got berr=%b rdata=%h exp berr=1 rdata=0", be, rd); end
        for (int r = 0; r < 4; r++) begin
            xfer(0, 1'b0, 2'b10, BASE + 32'(4 * r), 32'd0, rd, be, lat, cm, af);
            tests++;
            if (rd !== m0[r]) begin fails++; $display("FAIL err_unchanged reg=%0d got=%h exp=%h", r, rd, m0[r]); end
        end
    endtask

    task automatic test_count_irq();
        logic [31:0] rd; logic be, af; int lat, e, c, r;
        xfer(0, 1'b1, 2'b10, BASE + 32'h00, 32'd0, rd, be, lat, c, af);
        xfer(0, 1'b1, 2'b10, BASE + 32'h04, 32'd0, rd, be, lat, c, af);
        xfer(0, 1'b1, 2'b10, BASE + 32'h0C, 32'd0, rd, be, lat, c, af);
        xfer(0, 1'b1, 2'b10, BASE + 32'h08, 32'd5, rd, be, lat, c, af);
        xfer(0, 1'b1, 2'b10, BASE + 32'h10, 32'd1, rd, be, lat, e, af);
        for (int j = 0; j < 8; j++) begin
            tests++;
            if (irq_s[0] !== ((cyc - e) >= 5)) begin
                fails++; $display("FAIL count_irq mtime=%0d got=%b exp=%b", cyc - e, irq_s[0], (cyc - e) >= 5);
            end
            @(posedge clk); #1;
        end
        xfer(0, 1'b1, 2'b10, BASE + 32'h08, 32'd100, rd, be, lat, c, af);
        tests++;
        if (irq_s[0] !== 1'b0) begin fails++; $display("FAIL irq_clear got=%b exp=0", irq_s[0]); end
        xfer(0, 1'b0, 2'b10, BASE + 32'h00, 32'd0, rd, be, lat, r, af);
        tests++;
        if (rd !== 32'(r - 1 - e)) begin fails++; $display("FAIL count_value got=%0d exp=%0d", rd, r - 1 - e); end
    endtask

    task automatic test_carry_write_wins();
        logic [31:0] rd; logic be, af; int lat, c, e, d, w;
        xfer(0, 1'b1, 2'b10, BASE + 32'h10, 32'd0, rd, be, lat, c, af);
        xfer(0, 1'b1, 2'b10, BASE + 32'h00, 32'hFFFF_FFFF, rd, be, lat, c, af);
        xfer(0, 1'b1, 2'b10, BASE + 32'h04, 32'd0, rd, be, lat, c, af);
        xfer(0, 1'b1, 2'b10, BASE + 32'h10, 32'd1, rd, be, lat, e, af);
        xfer(0, 1'b1, 2'b10, BASE + 32'h10, 32'd0, rd, be, lat, d, af);
        xfer(0, 1'b0, 2'b10, BASE + 32'h04, 32'd0, rd, be, lat, c, af);
        tests++;
        if (rd !== 32'd1) begin fails++; $display("FAIL carry_hi got=%h exp=1", rd); end
        xfer(0, 1'b0, 2'b10, BASE + 32'h00, 32'd0, rd, be, lat, c, af);
        tests++;
        if (rd !== 32'(d - e - 1)) begin fails++; $display("FAIL carry_lo got=%0d exp=%0d", rd, d - e - 1); end
        xfer(0, 1'b1, 2'b10, BASE + 32'h10, 32'd1, rd, be, lat, e, af);
        xfer(0, 1'b1, 2'b10, BASE + 32'h00, 32'h10, rd, be, lat, w, af);
        xfer(0, 1'b1, 2'b10, BASE + 32'h10, 32'd0, rd, be, lat, d, af);
        xfer(0, 1'b0, 2'b10, BASE + 32'h00, 32'd0, rd, be, lat, c, af);
        tests++;
        if (rd !== 32'(32'h10 + d - w)) begin fails++; $display("FAIL write_wins_lo got=%h exp=%h", rd, 32'h10 + d - w); end
        xfer(0, 1'b0, 2'b10, BASE + 32'h04, 32'd0, rd, be, lat, c, af);
        tests++;
        if (rd !== 32'd1) begin fails++; $display("FAIL write_wins_hi got=%h exp=1", rd); end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        ttype_s[0] = READ; tsize_s[0] = WORD; addr_s[0] = BASE + 32'h08; bstart_s[0] = 1'b1; breq_s[0] = 1'b1;
        for (int e = 0; e < 6; e++) begin
            @(posedge clk); #1;
            tests++;
            if (bdone_s[0] !== (e % 2 == 0)) begin fails++; $display("FAIL b2b_bdone edge=%0d got=%b exp=%b", e, bdone_s[0], e % 2 == 0); end
            if (e % 2 == 0) begin
                tests++;
                if (rdata_s[0] !== 32'd100) begin fails++; $display("FAIL b2b_rdata edge=%0d got=%h exp=64", e, rdata_s[0]); end
            end
        end
        bstart_s[0] = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (bdone_s[0] !== 1'b0) begin fails++; $display("FAIL b2b_stop got=%b exp=0", bdone_s[0]); end
    endtask

    task automatic test_wait_prescale();
        logic [31:0] rd; logic be, af; int lat, c, e, r, d, v;
        xfer(1, 1'b0, 2'b10, BASE + 32'h08, 32'd0, rd, be, lat, c, af);
        tests++;
        if (lat !== 1 + WS[1]) begin fails++; $display("FAIL wait_latency got=%0d exp=%0d", lat, 1 + WS[1]); end
        tests++;
        if (rd !== 32'hFFFF_FFFF || af !== 1'b0) begin fails++; $display("FAIL wait_read got=%h after=%b exp=ffffffff after=0", rd, af); end
        xfer(1, 1'b1, 2'b10, BASE + 32'h10, 32'd1, rd, be, lat, e, af);
        xfer(1, 1'b0, 2'b10, BASE + 32'h00, 32'd0, rd, be, lat, r, af);
        tests++;
        if (rd !== 32'((r - 1 - e) / PS1)) begin fails++; $display("FAIL presc_mid got=%0d exp=%0d", rd, (r - 1 - e) / PS1); end
        xfer(1, 1'b1, 2'b10, BASE + 32'h10, 32'd0, rd, be, lat, d, af);
        v = (d - e) / PS1;
        xfer(1, 1'b1, 2'b10, BASE + 32'h10, 32'd1, rd, be, lat, e, af);
        repeat ($urandom_range(0, 4)) @(posedge clk);
        xfer(1, 1'b1, 2'b10, BASE + 32'h10, 32'd0, rd, be, lat, d, af);
        v = v + (d - e) / PS1;
        xfer(1, 1'b0, 2'b10, BASE + 32'h00, 32'd0, rd, be, lat, c, af);
        tests++;
        if (rd !== 32'(v)) begin fails++; $display("FAIL presc_total got=%0d exp=%0d", rd, v); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic be, af, seen; int lat, c;
        xfer(1, 1'b1, 2'b10, BASE + 32'h10, 32'd1, rd, be, lat, c, af);
        @(posedge clk); #1;
        ttype_s[1] = WRITE; tsize_s[1] = WORD; addr_s[1] = BASE + 32'h08; wdata_s[1] = 32'h1234;
        bstart_s[1] = 1'b1; breq_s[1] = 1'b1;
        @(posedge clk); #1;
        bstart_s[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #2 rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (bdone_s[1] === 1'b1) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0) begin fails++; $display("FAIL reset_abort got bdone=1 exp none"); end
        tests++;
        if (irq_s[0] !== 1'b0 || irq_s[1] !== 1'b0) begin fails++; $display("FAIL reset_mid_irq got=%b%b exp=00", irq_s[0], irq_s[1]); end
        xfer(1, 1'b0, 2'b10, BASE + 32'h08, 32'd0, rd, be, lat, c, af);
        tests++;
        if (lat !== 1 + WS[1] || rd !== 32'hFFFF_FFFF) begin fails++; $display("FAIL reset_mid_cmp got lat=%0d rdata=%h exp lat=4 rdata=ffffffff", lat, rd); end
        xfer(1, 1'b0, 2'b10, BASE + 32'h10, 32'd0, rd, be, lat, c, af);
        tests++;
        if (rd !== 32'd0) begin fails++; $display("FAIL reset_mid_ctrl got=%h exp=0", rd); end
        xfer(1, 1'b0, 2'b10, BASE + 32'h00, 32'd0, rd, be, lat, c, af);
        tests++;
        if (rd !== 32'd0) begin fails++; $display("FAIL reset_mid_mtime got=%h exp=0", rd); end
        xfer(0, 1'b0, 2'b10, BASE + 32'h0C, 32'd0, rd, be, lat, c, af);
        tests++;
        if (rd !== 32'hFFFF_FFFF) begin fails++; $display("FAIL reset_mid_inst0 got=%h exp=ffffffff", rd); end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            bstart_s[s] = 1'b0;
            breq_s[s]   = 1'b0;
            ttype_s[s]  = READ;
            tsize_s[s]  = WORD;
            addr_s[s]   = 32'd0;
            wdata_s[s]  = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_word_read();
        test_byte_write();
        test_random();
        test_errors();
        test_count_irq();
        test_carry_write_wins();
        test_back_to_back();
        test_wait_prescale();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
